// File: rtl/dm_pkg.sv
// Shared encodings, FSM state type and size decode for the data-memory access unit.
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {StIdle, StLo, StHi, StResp} state_e;

  function automatic logic dm_valid(input logic [2:0] ctrl);
    return ctrl <= DM_BYTE_U;
  endfunction

  // Access size in bytes; invalid codes report 4 but are never split.
  function automatic logic [2:0] dm_size(input logic [2:0] ctrl);
    case (ctrl)
      DM_HALF, DM_HALF_U: return 3'd2;
      DM_BYTE, DM_BYTE_U: return 3'd1;
      default:            return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] dm_lanes(input logic [2:0] size);
    case (size)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dm_sram.sv
// Single-port word-wide SRAM with per-byte-lane write enables and a registered read port.
module dm_sram #(
  parameter int unsigned DEPTH_LOG2 = 7
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dm_access.sv
// Load/store unit: aligns byte/half/word accesses onto the word SRAM, splitting word-crossing ones.
module dm_access
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  dm_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic        busy,
  output logic        done,
  output logic [31:0] dout,
  output logic        err
);

  state_e                state_q;
  logic                  we_q;
  logic [2:0]            ctrl_q;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic [31:0]           din_q;
  logic [31:0]           rd_lo_q;

  logic                  valid, split;
  logic [2:0]            size;
  logic [1:0]            off;
  logic [3:0]            lanes;
  logic [DEPTH_LOG2-1:0] word;
  logic [63:0]           wdata64, rdata64;
  logic [7:0]            be64;
  logic [31:0]           shifted, loaded;
  logic [DEPTH_LOG2-1:0] sram_addr;
  logic [3:0]            sram_be;
  logic [31:0]           sram_wdata, sram_rdata;
  logic                  unused_addr;

  assign unused_addr = ^addr[31:DEPTH_LOG2+2];

  assign valid   = dm_valid(ctrl_q);
  assign size    = dm_size(ctrl_q);
  assign lanes   = dm_lanes(size);
  assign off     = addr_q[1:0];
  assign word    = addr_q[DEPTH_LOG2+1:2];
  assign split   = valid && ({1'b0, off} + size > 3'd4);
  assign wdata64 = {32'b0, din_q & {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}}}
                   << {off, 3'b000};
  assign be64    = {4'b0, lanes} << off;

  always_comb begin
    sram_addr  = word;
    sram_be    = '0;
    sram_wdata = wdata64[31:0];
    unique case (state_q)
      StLo: if (we_q && valid && !reset) sram_be = be64[3:0];
      StHi: begin
        sram_addr  = word + DEPTH_LOG2'(1);
        sram_wdata = wdata64[63:32];
        // Gate with reset so an interrupted split store leaves word w+1 untouched.
        if (we_q && valid && !reset) sram_be = be64[7:4];
      end
      default: ;
    endcase
  end

  dm_sram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk  (clk),
    .addr (sram_addr),
    .be   (sram_be),
    .wdata(sram_wdata),
    .rdata(sram_rdata)
  );

  // In RESP the SRAM output holds word w for a single access, word w+1 for a split one.
  assign rdata64 = split ? {sram_rdata, rd_lo_q} : {32'b0, sram_rdata};
  assign shifted = 32'(rdata64 >> {off, 3'b000});

  always_comb begin
    loaded = '0;
    case (ctrl_q)
      DM_WORD:   loaded = shifted;
      DM_HALF:   loaded = {{16{shifted[15]}}, shifted[15:0]};
      DM_HALF_U: loaded = {16'b0, shifted[15:0]};
      DM_BYTE:   loaded = {{24{shifted[7]}}, shifted[7:0]};
      DM_BYTE_U: loaded = {24'b0, shifted[7:0]};
      default:   loaded = '0;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StResp);
  assign err  = done && !valid;
  assign dout = (done && valid && !we_q) ? loaded : 32'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      ctrl_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rd_lo_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            we_q    <= we;
            ctrl_q  <= dm_ctrl;
            addr_q  <= addr[DEPTH_LOG2+1:0];
            din_q   <= din;
            state_q <= StLo;
          end
        end
        StLo: state_q <= split ? StHi : StResp;
        StHi: begin
          rd_lo_q <= sram_rdata;
          state_q <= StResp;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access.sv
// Randomized bench for dm_access against a byte-addressed memory model, plus directed literal checks.
module tb_dm_access;

  localparam int Bytes = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [2:0]  dm_ctrl;
  logic [31:0] addr, din;
  logic        busy, done, err;
  logic [31:0] dout;

  dm_access #(
    .DEPTH_LOG2(7)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .dm_ctrl(dm_ctrl),
    .addr   (addr),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .dout   (dout),
    .err    (err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  mem_m [Bytes];
  logic        chk_en = 1'b0;
  logic        exp_busy, exp_done, exp_err, exp_dout_chk;
  logic [31:0] exp_dout;
  logic [31:0] last_dout;
  logic        last_err;
  int          done_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      check("done", {31'b0, done}, {31'b0, exp_done});
      check("err", {31'b0, err}, {31'b0, exp_err});
      if (exp_dout_chk) check("dout", dout, exp_dout);
    end
  end

  task automatic set_exp(input logic b, input logic d, input logic [31:0] o, input logic e,
                         input logic oc);
    exp_busy = b; exp_done = d; exp_dout = o; exp_err = e; exp_dout_chk = oc;
  endtask

  function automatic int sz(input logic [2:0] c);
    if (c == 3'd0) return 4;
    if (c == 3'd1 || c == 3'd2) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a);
    logic [31:0] v = '0;
    for (int i = 0; i < sz(c); i++) v[8*i +: 8] = mem_m[(int'(a[8:0]) + i) % Bytes];
    if (c == 3'd1 && v[15]) v[31:16] = 16'hffff;
    if (c == 3'd3 && v[7]) v[31:8] = 24'hffffff;
    return v;
  endfunction

  // lo_only: only bytes that land in the first word (interrupted split store).
  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input int n,
                             input bit lo_only);
    for (int i = 0; i < n; i++)
      if (!lo_only || int'(a[1:0]) + i < 4) mem_m[(int'(a[8:0]) + i) % Bytes] = d[8*i +: 8];
  endtask

  // Called in an IDLE cycle (#1+ after posedge); returns in the IDLE cycle after RESP.
  task automatic access(input logic w, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d);
    bit          valid, split;
    int          lat;
    logic [31:0] res;
    valid = (c <= 3'd4);
    split = valid && (int'(a[1:0]) + sz(c) > 4);
    lat   = split ? 3 : 2;
    res   = (valid && !w) ? model_load(c, a) : 32'b0;
    if (valid && w) model_store(a, d, sz(c), 1'b0);
    req = 1'b1; we = w; dm_ctrl = c; addr = a; din = d;
    set_exp(1'b0, 1'b0, 32'b0, 1'b0, 1'b1);
    done_at   = -1;
    last_dout = 32'hxxxxxxxx;
    last_err  = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk); #1;
      if (k <= lat) begin
        // Garbage requests while busy must be ignored.
        req     = 1'($urandom_range(0, 1));
        we      = 1'($urandom_range(0, 1));
        dm_ctrl = 3'($urandom_range(0, 7));
        addr    = $urandom;
        din     = $urandom;
        set_exp(1'b1, k == lat, (k == lat) ? res : 32'b0, (k == lat) && !valid,
                !(valid && w) || k != lat);
      end else begin
        req = 1'b0;
        set_exp(1'b0, 1'b0, 32'b0, 1'b0, 1'b1);
      end
      #2;
      if (done && done_at < 0) begin
        done_at   = k;
        last_dout = dout;
        last_err  = err;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    req = 1'b0;
    set_exp(1'b0, 1'b0, 32'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; dm_ctrl = '0; addr = '0; din = '0;
    set_exp(1'b0, 1'b0, 32'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1;
    check("reset_dout", dout, 32'b0);
    reset = 1'b0;

    for (int w = 0; w < 128; w++) access(1'b1, 3'd0, 32'(w * 4), $urandom);

    access(1'b1, 3'd0, 32'h10, 32'h11223344);
    check("sw_lat", 32'(done_at), 32'd2);
    access(1'b0, 3'd0, 32'h10, 32'h0);
    check("lw_10", last_dout, 32'h11223344);
    check("lw_lat", 32'(done_at), 32'd2);

    access(1'b1, 3'd3, 32'h13, 32'h000000a5);
    access(1'b0, 3'd3, 32'h13, 32'h0);
    check("lb_13", last_dout, 32'hffffffa5);
    access(1'b0, 3'd4, 32'h13, 32'h0);
    check("lbu_13", last_dout, 32'h000000a5);
    access(1'b0, 3'd0, 32'h10, 32'h0);
    check("lw_10b", last_dout, 32'ha5223344);

    access(1'b1, 3'd0, 32'h0e, 32'hdeadbeef);
    check("sw_split_lat", 32'(done_at), 32'd3);
    access(1'b0, 3'd0, 32'h10, 32'h0);
    check("lw_10c", last_dout, 32'ha522dead);
    access(1'b0, 3'd1, 32'h0f, 32'h0);
    check("lh_0f", last_dout, 32'hffffadbe);
    check("lh_split_lat", 32'(done_at), 32'd3);

    access(1'b1, 3'd1, 32'h1ff, 32'h1234);
    access(1'b0, 3'd4, 32'h1ff, 32'h0);
    check("wrap_b1ff", last_dout, 32'h34);
    access(1'b0, 3'd4, 32'h000, 32'h0);
    check("wrap_b000", last_dout, 32'h12);
    access(1'b0, 3'd2, 32'h1ff, 32'h0);
    check("lhu_1ff", last_dout, 32'h00001234);

    access(1'b1, 3'd7, 32'h10, 32'hcafef00d);
    check("inv_err", {31'b0, last_err}, 32'd1);
    check("inv_lat", 32'(done_at), 32'd2);
    access(1'b0, 3'd0, 32'h10, 32'h0);
    check("inv_keep", last_dout, 32'ha522dead);

    // Split store interrupted by reset during HI.
    req = 1'b1; we = 1'b1; dm_ctrl = 3'd0; addr = 32'h0e; din = 32'h01020304;
    set_exp(1'b0, 1'b0, 32'b0, 1'b0, 1'b1);
    model_store(32'h0e, 32'h01020304, 4, 1'b1);
    @(posedge clk); #1;
    req = 1'b1; addr = 32'h40;
    set_exp(1'b1, 1'b0, 32'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    req = 1'b0; reset = 1'b1;
    set_exp(1'b1, 1'b0, 32'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    set_exp(1'b0, 1'b0, 32'b0, 1'b0, 1'b1);
    idle_cycle();
    access(1'b0, 3'd4, 32'h0e, 32'h0);
    check("rst_b0e", last_dout, 32'h04);
    access(1'b0, 3'd4, 32'h0f, 32'h0);
    check("rst_b0f", last_dout, 32'h03);
    access(1'b0, 3'd0, 32'h10, 32'h0);
    check("rst_w4", last_dout, 32'ha522dead);

    for (int t = 0; t < 300; t++) begin
      logic [2:0]  c;
      logic [31:0] a;
      repeat ($urandom_range(0, 2)) idle_cycle();
      c = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[8:6] = 3'b000;
      access(1'($urandom_range(0, 1)), c, a, $urandom);
    end

    idle_cycle();
    @(posedge clk); #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_access.md
# dm_access

Data-memory access unit for the single-cycle RISC-V core. It is the consumer end of the decoder's `MemWrite`/`dm_ctrl` outputs. It turns one load/store request (byte, halfword or word) into accesses on an internal word-wide byte-enable SRAM. Misaligned accesses that cross a word boundary are split into two word accesses. Load data is returned sign- or zero-extended. The core stalls on `busy`.

## Interface
- `DEPTH_LOG2`, default 7: log2 of SRAM depth in 32-bit words (default 128 words, 512 bytes).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req` input 1: access request, sampled only while `busy`=0.
- `we` input 1: 1 = store, 0 = load (the decoder's `MemWrite`).
- `dm_ctrl` input 3: access type.
  - 000 word
  - 001 half
  - 010 half unsigned
  - 011 byte
  - 100 byte unsigned
  - 101–111 invalid
- `addr` input 32: byte address.
- `din` input 32: store data, right-justified.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle completion pulse.
- `dout` output 32: extended load data; valid only while `done`=1, otherwise 0.
- `err` output 1: high with `done` when `dm_ctrl` was invalid.

## Operation
- Size n: 4 for 000; 2 for 001/010; 1 for 011/100.
- Store with 010 or 100 behaves as half or byte store respectively.
- Address decomposition: word index w = addr[DEPTH_LOG2+1:2], offset o = addr[1:0].
  - Upper address bits are ignored.
  - w+1 wraps modulo 2^DEPTH_LOG2.
- Split access when o+n > 4.
- Stores:
  - din is masked to n bytes and shifted left by 8·o into a 64-bit value.
  - The low 32 bits are written to word w with byte enables for lanes o..min(3, o+n−1).
  - If split, the high 32 bits are written to w+1 with enables for lanes 0..o+n−5.
- Loads:
  - {rd_hi, rd_lo} is shifted right by 8·o, then the low n bytes are kept.
  - Codes 001 and 011 sign-extend; 000, 010 and 100 zero-fill.
  - For a non-split access, rd_hi is treated as 0.
- Invalid `dm_ctrl`:
  - The request is accepted and no SRAM write occurs.
  - The normal non-split state sequence is still traversed.
  - `dout`=0, `err`=1 with `done`.
- FSM states: IDLE, LO, HI, RESP.
  - IDLE: if `req`=1, latch we, dm_ctrl, addr and din, then go to LO.
  - LO: drive word w with the low enables (write, or read when we=0). Go to HI if split, else RESP.
  - HI: register rd_lo, drive word w+1. Go to RESP.
  - RESP: `done`=1; `dout` is assembled combinationally from the SRAM output and the rd_lo register. Always go to IDLE.
- `busy` = (state != IDLE). Requests are never accepted in RESP.
- SRAM contents are not affected by reset.

## Timing
- Reset:
  - state = IDLE.
  - `busy`, `done`, `err` = 0 and `dout` = 0.
  - rd_lo register and latched request fields = 0.
- Cycle 0 is the cycle in which `req` is sampled high in IDLE.
- Non-split access:
  - Cycle 1 is LO; cycle 2 is RESP with `done`=1.
  - `busy` is high in cycles 1–2.
- Split access:
  - Cycles 1 and 2 are LO and HI; cycle 3 is RESP.
  - `busy` is high in cycles 1–3.
- The SRAM has a one-cycle synchronous read: an address driven in cycle k gives data in cycle k+1. A write commits at the end of cycle k.
- Back-to-back requests: the earliest next acceptance is the IDLE cycle after RESP. Peak throughput is one access per 3 cycles (split: 4).
- `req` is ignored while `busy`=1. Inputs need not be held after cycle 0.
- Reset asserted in any state puts the unit in IDLE in the next cycle with no `done`.
  - A split store reset during HI has already written word w; word w+1 is unchanged.

## Structure
- Package `dm_pkg` holds:
  - the `dm_ctrl` encodings (DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U);
  - the FSM state enum;
  - the size-decode function.
- Sub-module `dm_sram`: 2^DEPTH_LOG2 × 32-bit, 4 byte lanes, single port, synchronous read, per-lane write enable, no reset.
- `dm_access` contains the FSM, alignment shifters and extension logic.

## Test plan
- **Word store and load:** sw addr 0x10, din 0x11223344, then lw 0x10 → `done` in cycle 2 with `dout`=0x11223344; `busy` high for exactly 2 cycles each.
- **Byte extension:** sb 0x13, din 0x000000A5, then lb 0x13 → 0xFFFFFFA5 and lbu 0x13 → 0x000000A5. lw 0x10 → 0xA5223344.
- **Split store and loads:**
  - sw 0x0E, din 0xDEADBEEF → 3-cycle busy.
  - Then lw 0x10 → 0xA522DEAD.
  - lh 0x0F → 0xFFFFADBE, with `done` in cycle 3.
- **Address wrap:** sh 0x1FF, din 0x1234 (DEPTH_LOG2=7) → byte 0x1FF = 0x34 and byte 0x000 = 0x12; lhu 0x1FF → 0x00001234.
- **Invalid type:** store with dm_ctrl 3'b111 to 0x10 → `done`=`err`=1 in cycle 2; subsequent lw 0x10 returns the prior value unchanged.
- **Reset mid-split:** reset during HI of sw 0x0E, din 0x01020304 → next cycle `busy`=`done`=0. Word 3 lanes 2–3 hold 0x04 and 0x03; word 4 is unchanged. Also check a `req` pulse held during `busy` is ignored.
